// File: rtl/step_ctrl_pkg.sv
// rtl/step_ctrl_pkg.sv - opcode, state and done_reason constants for step_ctrl
package step_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_STEP = 2'd1,
    OP_RUN  = 2'd2,
    OP_STOP = 2'd3
  } op_t;

  // LAUNCH is the one-cycle gap between acceptance and the first enabled cycle
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] ST_STEP   = 2'd3;

  typedef enum logic [1:0] {
    RSN_COUNT = 2'd0,
    RSN_STOP  = 2'd1,
    RSN_HALT  = 2'd2
  } reason_t;

endpackage

// File: rtl/step_ctrl_counter.sv
// rtl/step_ctrl_counter.sv - loadable down-counter with zero and last-count flags
module step_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero,
  output logic         last
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);
  assign last = (cnt == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/step_ctrl.sv
// rtl/step_ctrl.sv - run/step enable sequencer with stop/halt termination and cycle tally
module step_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int TOT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             stop,
  input  logic             halt_in,
  output logic             en,
  output logic             busy,
  output logic             done,
  output logic [1:0]       done_reason,
  output logic [TOT_W-1:0] cycles
);

  logic [1:0] state;
  logic [1:0] nxt_state;
  logic       nxt_en;
  logic       pend_run;
  logic       pend_halt;
  logic       cnt_zero;
  logic       cnt_last;
  logic       accept;
  logic       start;
  logic       term;
  reason_t    term_reason;
  op_t        op;

  assign op        = op_t'(cmd_op);
  assign cmd_ready = (state == ST_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign start     = accept && ((op == OP_STEP) || (op == OP_RUN));
  assign busy      = (state == ST_RUN) || (state == ST_STEP);

  step_counter #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept && (op == OP_STEP)),
    .load_val (cmd_count),
    .dec      (state == ST_STEP),
    .zero     (cnt_zero),
    .last     (cnt_last)
  );

  // Termination priority is stop, then halt, then count exhaustion.
  always_comb begin
    term        = 1'b0;
    term_reason = RSN_COUNT;
    nxt_state   = state;
    nxt_en      = en;
    case (state)
      ST_IDLE: begin
        if (start) nxt_state = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        if (stop) begin
          term        = 1'b1;
          term_reason = RSN_STOP;
        end else if (halt_in || pend_halt) begin
          term        = 1'b1;
          term_reason = RSN_HALT;
        end else if (!pend_run && cnt_zero) begin
          term        = 1'b1;
          term_reason = RSN_COUNT;
        end else begin
          nxt_state = pend_run ? ST_RUN : ST_STEP;
          nxt_en    = 1'b1;
        end
      end
      default: begin
        if (stop) begin
          term        = 1'b1;
          term_reason = RSN_STOP;
        end else if (halt_in) begin
          term        = 1'b1;
          term_reason = RSN_HALT;
        end else if ((state == ST_STEP) && cnt_last) begin
          term        = 1'b1;
          term_reason = RSN_COUNT;
        end
      end
    endcase
    if (term) begin
      nxt_state = ST_IDLE;
      nxt_en    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      en          <= 1'b0;
      done        <= 1'b0;
      done_reason <= 2'd0;
      cycles      <= '0;
      pend_run    <= 1'b0;
      pend_halt   <= 1'b0;
    end else begin
      state  <= nxt_state;
      en     <= nxt_en;
      done   <= term;
      cycles <= cycles + {{(TOT_W-1){1'b0}}, en};
      if (term) done_reason <= term_reason;
      // halt seen at acceptance must still cancel the sequence even if it drops
      if (start) begin
        pend_run  <= (op == OP_RUN);
        pend_halt <= halt_in;
      end
    end
  end

endmodule

// File: tb/tb_step_ctrl.sv
// tb/tb_step_ctrl.sv - self-checking bench for step_ctrl
module tb_step_ctrl;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_count;
  logic        stop;
  logic        halt_in;
  logic        cmd_ready, en, busy, done;
  logic [1:0]  done_reason;
  logic [15:0] cycles;
  logic        cmd_ready4, en4, busy4, done4;
  logic [1:0]  done_reason4;
  logic [3:0]  cycles4;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cycles = 0;

  step_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_count(cmd_count), .stop(stop), .halt_in(halt_in),
    .en(en), .busy(busy), .done(done), .done_reason(done_reason), .cycles(cycles)
  );

  step_ctrl #(.TOT_W(4)) dut4 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready4),
    .cmd_op(cmd_op), .cmd_count(cmd_count), .stop(stop), .halt_in(halt_in),
    .en(en4), .busy(busy4), .done(done4), .done_reason(done_reason4), .cycles(cycles4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int op;
    int n;
    int stop_at;
    int halt_at;
    bit halt_pre;
    bit stop_acc;
    int exp_en;
    int exp_rsn;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Transaction-level expectation: enabled cycles are the earliest of the
  // limits, ties resolved stop > halt > count.
  function automatic void model(input int op, input int n, input int stop_at, input int halt_at,
                                input bit halt_pre, output int e, output int r);
    if (halt_pre) begin
      e = 0;
      r = 2;
      return;
    end
    e = 1 << 30;
    if (op == 1) e = n;
    if (stop_at != 0 && stop_at < e) e = stop_at;
    if (halt_at != 0 && halt_at < e) e = halt_at;
    if (stop_at != 0 && stop_at == e)      r = 1;
    else if (halt_at != 0 && halt_at == e) r = 2;
    else                                   r = 0;
  endfunction

  task automatic run_txn(input vec_t v);
    int ec, lat;
    bit seen;
    lat = 0;
    while (!cmd_ready && lat < 50) begin
      tick();
      lat++;
    end
    check("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = 2'(v.op);
    cmd_count = 8'(v.n);
    halt_in   = v.halt_pre;
    stop      = v.stop_acc;
    tick();
    cmd_valid = 1'b0;
    stop      = 1'b0;
    ec = 0;
    lat = 0;
    seen = 1'b0;
    while (lat < 600) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (en) ec++;
      check("busy_tracks_en", busy, en);
      stop    = (v.stop_at != 0) && (ec == v.stop_at);
      halt_in = v.halt_pre || ((v.halt_at != 0) && (ec >= v.halt_at));
      tick();
      lat++;
    end
    stop    = 1'b0;
    halt_in = 1'b0;
    exp_cycles += v.exp_en;
    check("done_seen", seen, 1);
    check("en_cycles", ec, v.exp_en);
    check("done_latency", lat, v.exp_en + 1);
    check("done_reason", done_reason, v.exp_rsn);
    check("en_at_done", en, 0);
    check("busy_at_done", busy, 0);
    check("ready_at_done", cmd_ready, 1);
    check("cycles", cycles, exp_cycles % 65536);
    check("cycles4", cycles4, exp_cycles % 16);
  endtask

  vec_t vecs[13];

  initial begin
    vec_t rv;
    int e, r;
    vecs[0]  = '{1, 3,   0,  0, 1'b0, 1'b0, 3,   0};
    vecs[1]  = '{1, 0,   0,  0, 1'b0, 1'b0, 0,   0};
    vecs[2]  = '{2, 0,  10,  0, 1'b0, 1'b0, 10,  1};
    vecs[3]  = '{1, 8,   4,  4, 1'b0, 1'b0, 4,   1};
    vecs[4]  = '{1, 8,   0,  4, 1'b0, 1'b0, 4,   2};
    vecs[5]  = '{2, 0,   0,  0, 1'b1, 1'b0, 0,   2};
    vecs[6]  = '{1, 5,   0,  0, 1'b1, 1'b0, 0,   2};
    vecs[7]  = '{1, 5,   5,  0, 1'b0, 1'b0, 5,   1};
    vecs[8]  = '{1, 5,   0,  5, 1'b0, 1'b0, 5,   2};
    vecs[9]  = '{1, 1,   0,  0, 1'b0, 1'b0, 1,   0};
    vecs[10] = '{1, 2,   0,  0, 1'b0, 1'b1, 2,   0};
    vecs[11] = '{2, 0,   7,  3, 1'b0, 1'b0, 3,   2};
    vecs[12] = '{1, 255, 0,  0, 1'b0, 1'b0, 255, 0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_count = 8'd0;
    stop = 1'b0; halt_in = 1'b0;
    tick();
    check("ready_in_reset", cmd_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    check("rst_en", en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_reason", done_reason, 0);
    check("rst_cycles", cycles, 0);
    check("rst_ready", cmd_ready, 1);

    // NOP then STOP accepted in IDLE: nothing happens
    cmd_valid = 1'b1; cmd_op = 2'd0;
    tick();
    cmd_op = 2'd3;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("nop_done", done, 0);
      check("nop_en", en, 0);
      check("nop_ready", cmd_ready, 1);
      tick();
    end

    for (int i = 0; i < 13; i++) run_txn(vecs[i]);

    // reset in the middle of RUN: no done, cycles cleared
    cmd_valid = 1'b1; cmd_op = 2'd2;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("run_en_before_rst", en, 1);
    rst = 1'b1;
    #1;
    check("ready_during_rst", cmd_ready, 0);
    tick();
    rst = 1'b0;
    exp_cycles = 0;
    check("midrst_en", en, 0);
    check("midrst_done", done, 0);
    check("midrst_cycles", cycles, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midrst_no_done", done, 0);
    end
    rv = '{1, 1, 0, 0, 1'b0, 1'b0, 1, 0};
    run_txn(rv);

    // narrow counter wrap
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cycles = 0;
    rv = '{2, 0, 18, 0, 1'b0, 1'b0, 18, 1};
    run_txn(rv);
    check("wrap4", cycles4, 2);
    check("nowrap16", cycles, 18);

    for (int i = 0; i < 40; i++) begin
      rv.op       = ($urandom_range(0, 1) == 0) ? 1 : 2;
      rv.n        = $urandom_range(0, 20);
      rv.stop_at  = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 25);
      rv.halt_at  = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 25);
      rv.halt_pre = ($urandom_range(0, 7) == 0);
      rv.stop_acc = ($urandom_range(0, 3) == 0) && !rv.halt_pre;
      if (rv.halt_pre) begin
        rv.stop_at = 0;
        rv.halt_at = 0;
      end
      if (rv.op == 2 && rv.stop_at == 0 && rv.halt_at == 0 && !rv.halt_pre)
        rv.stop_at = $urandom_range(1, 25);
      model(rv.op, rv.n, rv.stop_at, rv.halt_at, rv.halt_pre, e, r);
      rv.exp_en  = e;
      rv.exp_rsn = r;
      run_txn(rv);
    end

    tick();
    check("final_done_pulse", done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/step_ctrl.md
STEP_CTRL -- requirements
Module: step_ctrl

Interface
REQ-001 Parameter CNT_W, default 8, width of the step-count field.
REQ-002 Parameter TOT_W, default 16, width of the total-enabled-cycle counter.
REQ-003 Port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 Port rst, input, 1, synchronous, active-high reset.
REQ-005 Port cmd_valid, input, 1, command offered this cycle.
REQ-006 Port cmd_ready, output, 1, block accepts a command this cycle.
REQ-007 Port cmd_op, input, 2, opcode: 0 NOP, 1 STEP, 2 RUN, 3 STOP.
REQ-008 Port cmd_count, input, CNT_W, cycle count for STEP; ignored otherwise.
REQ-009 Port stop, input, 1, asynchronous-intent stop request, sampled on clk, honoured in any state.
REQ-010 Port halt_in, input, 1, level halt from the CPU, sampled on clk.
REQ-011 Port en, output, 1, registered enable driving the edgegate en input.
REQ-012 Port busy, output, 1, high while in RUN or STEP.
REQ-013 Port done, output, 1, single-cycle pulse when a RUN/STEP sequence ends.
REQ-014 Port done_reason, output, 2, valid with done: 0 count exhausted, 1 stop/STOP, 2 halt_in.
REQ-015 Port cycles, output, TOT_W, total count of cycles with en=1 since reset.

Function
REQ-016 States: IDLE, RUN, STEP; en=1 exactly in RUN and STEP; en is a flop output, never combinational.
REQ-017 cmd_ready=1 only in IDLE; a command is accepted on an edge where cmd_valid and cmd_ready are both 1.
REQ-018 NOP or STOP accepted in IDLE: no state change, no done.
REQ-019 STEP with N>0 accepted at edge k: en=1 from edge k+1 through edge k+1+N, i.e. exactly N cycles high.
REQ-020 STEP with N=0: en stays 0; done=1, reason 0, in the cycle after acceptance.
REQ-021 RUN accepted at edge k: en=1 from edge k+1 until a stop or halt terminates.
REQ-022 stop=1 sampled in RUN/STEP at edge j: en=0 and state IDLE from edge j; done with reason 1 in that same cycle.
REQ-023 halt_in=1 sampled in RUN/STEP: same as REQ-022 with reason 2.
REQ-024 RUN/STEP accepted while halt_in=1: zero enabled cycles; done with reason 2 the next cycle.
REQ-025 Termination priority on the same edge: stop > halt_in > count exhausted; exactly one done pulse.
REQ-026 The STEP down-counter loads N on acceptance and decrements on each en=1 cycle; en falls on the edge the counter reaches 0.
REQ-027 cycles increments by 1 on every edge that ends a cycle with en=1 and wraps modulo 2^TOT_W without flagging.
REQ-028 stop=1 in IDLE has no effect and does not block a same-cycle command acceptance.
REQ-029 done is never high in two consecutive cycles; a new command is acceptable in the cycle done is high.

Reset
REQ-030 rst=1 at an edge forces state IDLE, en=0, busy=0, done=0, done_reason=0, cycles=0, step counter=0.
REQ-031 rst asserted mid-sequence terminates without a done pulse; cmd_ready=0 while rst=1.

Structure
REQ-032 Package step_ctrl_pkg holds the opcode constants, the state enum, and the done_reason codes.
REQ-033 Sub-module step_counter (loadable CNT_W down-counter with zero flag) is natural; cycles counter stays inline.

Verification
REQ-034 Reset, then STEP N=3 at edge 5 -> en high edges 6..9 (3 cycles), done reason 0 at cycle 9, cycles=3.
REQ-035 STEP N=0 -> en never rises, done reason 0 one cycle after acceptance, cycles unchanged.
REQ-036 RUN, stop pulse 10 cycles later -> en high exactly 10 cycles, done reason 1, cmd_ready returns to 1.
REQ-037 STEP N=8 with halt_in=1 raised after 4 enabled cycles and stop=1 on the same edge -> one done, reason 1, cycles=4.
REQ-038 TOT_W=4, RUN for 18 cycles then STOP via stop -> cycles=2 (wrap), no extra flag.
REQ-039 rst pulsed during RUN -> en=0 next cycle, no done, cycles=0, subsequent STEP N=1 works normally.
